// File: rtl/zero_detect_pipe.sv
// Pipelined WIDTH-bit zero/ones/equality detector: registered OR tree with a
// global-stall valid/ready pipeline, plus a saturating match-run counter and sticky flag.

module zero_detect_or_stage #(
    parameter int P      = 32,
    parameter int LEVELS = 1
) (
    input  logic [P-1:0] din,
    output logic [P-1:0] dout
);
    // Each level folds adjacent pairs into the low half; upper bits become zero.
    always_comb begin : reduce
        logic [P-1:0] v;
        logic [P-1:0] n;
        v = din;
        for (int l = 0; l < LEVELS; l++) begin
            n = '0;
            for (int i = 0; i < P / 2; i++) begin
                n[i] = v[2*i] | v[2*i+1];
            end
            v = n;
        end
        dout = v;
    end
endmodule

module zero_detect_pipe #(
    parameter int WIDTH        = 32,
    parameter int STAGE_LEVELS = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_cmp,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_match,
    output logic             out_nonzero,
    input  logic             clear,
    output logic [CNT_W-1:0] run_count,
    output logic             sticky_match
);
    localparam int D = $clog2(WIDTH);
    localparam int S = (D + STAGE_LEVELS - 1) / STAGE_LEVELS;
    localparam int P = 1 << D;

    logic [S:0]   vld_pipe;
    logic [P-1:0] vec    [0:S];
    logic [P-1:0] red    [1:S];
    logic [1:0]   mode_q [0:S];
    logic [P-1:0] t;
    logic         stall;
    logic         nz_raw;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    always_comb begin
        t = '0;
        case (in_mode)
            2'b00:   t[WIDTH-1:0] = in_data;
            2'b01:   t[WIDTH-1:0] = ~in_data;
            default: t[WIDTH-1:0] = in_data ^ in_cmp;
        endcase
    end

    // The last stage may need fewer levels than STAGE_LEVELS to finish the tree.
    for (genvar k = 1; k <= S; k++) begin : g_stage
        localparam int REM = D - (k - 1) * STAGE_LEVELS;
        localparam int L   = (REM < STAGE_LEVELS) ? REM : STAGE_LEVELS;
        zero_detect_or_stage #(.P(P), .LEVELS(L)) u_or (
            .din  (vec[k-1]),
            .dout (red[k])
        );
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            for (int k = 0; k <= S; k++) begin
                vec[k]    <= '0;
                mode_q[k] <= '0;
            end
        end else if (!stall) begin
            vld_pipe  <= {vld_pipe[S-1:0], in_valid};
            vec[0]    <= t;
            mode_q[0] <= in_mode;
            for (int k = 1; k <= S; k++) begin
                vec[k]    <= red[k];
                mode_q[k] <= mode_q[k-1];
            end
        end
    end

    // Outputs are gated by valid so bubbles and reset read as zero.
    assign nz_raw      = |vec[S];
    assign out_valid   = vld_pipe[S];
    assign out_nonzero = out_valid & nz_raw;
    assign out_match   = out_valid & ((mode_q[S] == 2'b11) ? nz_raw : !nz_raw);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_count    <= '0;
            sticky_match <= 1'b0;
        end else if (clear) begin
            run_count    <= '0;
            sticky_match <= 1'b0;
        end else if (out_valid && out_ready) begin
            if (out_match) begin
                if (run_count != '1) run_count <= run_count + 1'b1;
                sticky_match <= 1'b1;
            end else begin
                run_count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_zero_detect_pipe.sv
// Bench for zero_detect_pipe: directed steps plus a randomized phase checked
// against a queue-based reference model of results and the run counter.

module tb_zero_detect_pipe;
    localparam int LAT = 4;

    typedef struct packed {
        logic m;
        logic nz;
    } res_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
    logic [31:0] a_in_data = '0, a_in_cmp = '0;
    logic [1:0]  a_in_mode = '0;
    logic        a_out_match, a_out_nonzero, a_clear = 1'b0, a_sticky;
    logic [2:0]  a_run_count;

    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
    logic [19:0] b_in_data = '0, b_in_cmp = '0;
    logic [1:0]  b_in_mode = '0;
    logic        b_out_match, b_out_nonzero, b_clear = 1'b0, b_sticky;
    logic [7:0]  b_run_count;

    int   checks = 0;
    int   failures = 0;
    int   pops = 0;
    int   cnt = 0;
    logic stk = 1'b0;
    res_t q[$];

    always #5 clock = ~clock;

    zero_detect_pipe #(.WIDTH(32), .STAGE_LEVELS(2), .CNT_W(3)) dut_a (
        .clock(clock), .reset_n(reset_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_cmp(a_in_cmp), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_match(a_out_match), .out_nonzero(a_out_nonzero),
        .clear(a_clear), .run_count(a_run_count), .sticky_match(a_sticky)
    );

    zero_detect_pipe #(.WIDTH(20), .STAGE_LEVELS(1), .CNT_W(8)) dut_b (
        .clock(clock), .reset_n(reset_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_cmp(b_in_cmp), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_match(b_out_match), .out_nonzero(b_out_nonzero),
        .clear(b_clear), .run_count(b_run_count), .sticky_match(b_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t ref_res(input logic [1:0] m, input logic [31:0] d, input logic [31:0] c);
        res_t r;
        case (m)
            2'd0:    r.nz = (d != 32'd0);
            2'd1:    r.nz = (d != 32'hFFFF_FFFF);
            default: r.nz = (d != c);
        endcase
        r.m = (m == 2'd3) ? r.nz : !r.nz;
        return r;
    endfunction

    // One clock of the main instance: check head-of-queue result, update model.
    task automatic tick();
        logic inf, outf;
        res_t r;
        @(negedge clock);
        inf  = a_in_valid && a_in_ready;
        outf = a_out_valid && a_out_ready;
        if (a_out_valid) begin
            if (q.size() == 0) chk("spurious_valid", a_out_valid, 0);
            else begin
                chk("out_match", a_out_match, q[0].m);
                chk("out_nonzero", a_out_nonzero, q[0].nz);
            end
        end
        if (inf) q.push_back(ref_res(a_in_mode, a_in_data, a_in_cmp));
        @(posedge clock);
        if (outf && q.size() > 0) begin
            r = q.pop_front();
            pops++;
            if (!a_clear) begin
                if (r.m) begin
                    if (cnt < 7) cnt++;
                    stk = 1'b1;
                end else cnt = 0;
            end
        end
        if (a_clear) begin
            cnt = 0;
            stk = 1'b0;
        end
        #1;
        chk("run_count", a_run_count, cnt);
        chk("sticky", a_sticky, stk);
    endtask

    task automatic drain();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int g = 0; g < 50 && q.size() > 0; g++) tick();
        chk("drain_empty", q.size(), 0);
    endtask

    // Single operand: exact latency, constant expected match, then consumed.
    task automatic single(input logic [1:0] m, input logic [31:0] d, input logic [31:0] c,
                          input logic em, input string tag);
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_mode   = m;
        a_in_data   = d;
        a_in_cmp    = c;
        tick();
        a_in_valid = 1'b0;
        a_in_data  = $urandom;
        a_in_cmp   = $urandom;
        for (int n = 1; n < LAT; n++) begin
            chk({tag, "_early"}, a_out_valid, 0);
            tick();
        end
        chk({tag, "_valid"}, a_out_valid, 1);
        chk({tag, "_match"}, a_out_match, em);
        chk({tag, "_nz"}, a_out_nonzero, (m == 2'd3) ? em : !em);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_run_count", a_run_count, 0);
        chk("rst_sticky", a_sticky, 0);
        chk("rst_match", a_out_match, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        single(2'd0, 32'h0, 32'h0, 1'b1, "basic_zero");
        single(2'd0, 32'h8000_0000, 32'h0, 1'b0, "basic_msb");

        // Streaming: alternating zero / single set bit, one per cycle.
        a_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_in_valid = 1'b1;
            a_in_mode  = 2'd0;
            a_in_data  = (i % 2 == 0) ? 32'h0 : (32'h1 << i);
            tick();
            chk("stream_in_ready", a_in_ready, 1);
        end
        drain();

        // Backpressure: fill, stall 3 cycles, then drain exactly 4.
        for (int i = 0; i < LAT; i++) begin
            a_in_valid = 1'b1;
            a_in_mode  = 2'($urandom_range(0, 3));
            a_in_data  = (i % 2 == 0) ? 32'h0 : $urandom;
            a_in_cmp   = $urandom;
            tick();
        end
        a_out_ready = 1'b0;
        a_in_data   = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", a_in_ready, 0);
            chk("bp_out_valid", a_out_valid, 1);
        end
        pops = 0;
        drain();
        chk("bp_drain_count", pops, 4);

        single(2'd1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, "mode01");
        single(2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, "mode10_eq");
        single(2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEE, 1'b0, "mode10_ne");
        single(2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, "mode11_eq");
        single(2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEE, 1'b1, "mode11_ne");

        // Counter saturation, mismatch reset, clear coincident with a match.
        for (int i = 0; i < 9; i++) begin
            a_in_valid = 1'b1;
            a_in_mode  = 2'd0;
            a_in_data  = 32'h0;
            tick();
        end
        drain();
        chk("cnt_sat", a_run_count, 7);
        chk("cnt_sat_sticky", a_sticky, 1);
        single(2'd0, 32'h10, 32'h0, 1'b0, "cnt_miss");
        chk("cnt_miss_count", a_run_count, 0);
        chk("cnt_miss_sticky", a_sticky, 1);
        single(2'd0, 32'h0, 32'h0, 1'b1, "cnt_one");
        a_in_valid = 1'b1;
        a_in_data  = 32'h0;
        tick();
        a_in_valid = 1'b0;
        for (int n = 1; n < LAT; n++) tick();
        chk("clr_pre_valid", a_out_valid, 1);
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        chk("clr_count", a_run_count, 0);
        chk("clr_sticky", a_sticky, 0);
        chk("clr_delivered", a_out_valid, 0);
        chk("clr_queue", q.size(), 0);

        // Randomized traffic with backpressure and occasional clear.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] c;
            c = $urandom;
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 3) != 0);
            a_clear     = ($urandom_range(0, 15) == 0);
            a_in_mode   = 2'($urandom_range(0, 3));
            a_in_cmp    = c;
            case ($urandom_range(0, 4))
                0:       a_in_data = 32'h0;
                1:       a_in_data = 32'hFFFF_FFFF;
                2:       a_in_data = c;
                3:       a_in_data = c ^ (32'h1 << $urandom_range(0, 31));
                default: a_in_data = $urandom;
            endcase
            tick();
        end
        a_clear = 1'b0;
        drain();

        // Reset mid-stream with operands in flight.
        single(2'd0, 32'h0, 32'h0, 1'b1, "pre_rst");
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'h0;
            tick();
        end
        a_in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_count", a_run_count, 0);
        chk("mid_rst_sticky", a_sticky, 0);
        chk("mid_rst_in_ready", a_in_ready, 1);
        q.delete();
        cnt = 0;
        stk = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_valid", a_out_valid, 0);
        end
        single(2'd0, 32'h4, 32'h0, 1'b0, "post_rst_first");

        // Odd width: WIDTH=20, STAGE_LEVELS=1 -> LAT=6.
        chk("b_rst_count", b_run_count, 0);
        b_in_valid = 1'b1;
        b_in_mode  = 2'd0;
        b_in_data  = 20'h00001;
        @(negedge clock);
        @(posedge clock);
        #1 b_in_valid = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            if (n > 1) begin
                @(posedge clock);
                #1;
            end
            chk("b_lat_valid", b_out_valid, (n == 6) ? 1 : 0);
        end
        chk("b_lat_match", b_out_match, 0);
        chk("b_lat_nz", b_out_nonzero, 1);
        b_in_valid = 1'b1;
        b_in_mode  = 2'd1;
        b_in_data  = 20'hFFFFF;
        @(posedge clock);
        #1 b_in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("b_ones_valid", b_out_valid, 1);
        chk("b_ones_match", b_out_match, 1);
        chk("b_ones_nz", b_out_nonzero, 0);
        @(posedge clock);
        #1;
        chk("b_sticky", b_sticky, 1);
        chk("b_count", b_run_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
